// File: rtl/sdcard_error_pkg.sv
// Shared definitions for the SD-card error status unit.
//   - err_code_e  : error codes pushed into the event FIFO (1..8 per source, F = system)
//   - REG_*       : APB register byte offsets
//   - FIFO_DEPTH  : number of logged events held before overflow
//   - err_entry_t : one FIFO entry, {code, timestamp}
//   - lowest_code : maps an event vector to the code of its lowest set bit
package sdcard_error_pkg;

  typedef enum logic [3:0] {
    ERR_NONE          = 4'h0,
    ERR_CMD_TIMEOUT   = 4'h1,
    ERR_CMD_CRC       = 4'h2,
    ERR_DATA_CRC      = 4'h3,
    ERR_DMA           = 4'h4,
    ERR_POWER_FAULT   = 4'h5,
    ERR_TAMPER        = 4'h6,
    ERR_PERF_OVERFLOW = 4'h7,
    ERR_CAL_BUSY      = 4'h8,
    ERR_SYSTEM        = 4'hF
  } err_code_e;

  localparam logic [3:0] REG_STATUS    = 4'h0;
  localparam logic [3:0] REG_MASK      = 4'h4;
  localparam logic [3:0] REG_FIFO_DATA = 4'h8;
  localparam logic [3:0] REG_COUNT     = 4'hC;

  localparam int FIFO_DEPTH = 8;
  localparam int LEVEL_W    = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    err_code_e   code;
    logic [15:0] timestamp;
  } err_entry_t;

  localparam int ENTRY_W = $bits(err_entry_t);

  // Lowest set bit wins; scanning downwards lets the lowest index overwrite.
  function automatic err_code_e lowest_code(input logic [7:0] ev);
    err_code_e code;
    code = ERR_NONE;
    for (int i = 7; i >= 0; i--) begin
      if (ev[i]) code = err_code_e'(4'(i + 1));
    end
    return code;
  endfunction

endpackage

// File: rtl/sdcard_error_fifo.sv
// Event FIFO for the error status unit.
// Ports:
//   PCLK_i, PRESETn_i : clock, asynchronous active-low reset (clears pointers/level)
//   push, push_data   : write request and entry
//   pop               : read request; ignored when empty
//   head_data         : oldest entry, valid only while !empty
//   full, empty, level: occupancy
//   drop              : push refused because full with no pop in the same cycle
module sdcard_error_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 20,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             PCLK_i,
  input  logic             PRESETn_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty = (level_reg == '0);
  assign full  = (level_reg == LW'(DEPTH));
  assign level = level_reg;

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;

  // Contents are not reset; emptiness is tracked by the level alone.
  always_ff @(posedge PCLK_i) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Head is read asynchronously so FIFO_DATA returns in the same APB access cycle.
  assign head_data = mem[rd_ptr_reg];

endmodule

// File: rtl/sdcard_error_status_unit.sv
// SD-card error status unit: edge-detects raw error sources, keeps sticky status,
// logs timestamped events in a FIFO and exposes everything over APB.
// Ports:
//   PCLK_i, PRESETn_i          : APB clock, asynchronous active-low reset
//   PSEL_i/PENABLE_i/PWRITE_i  : APB control; PADDR_i 4-bit byte address; PWDATA_i
//   PRDATA_o, PREADY_o, PSLVERR_o : APB response (PREADY_o tied high)
//   err_src_i[7:0]             : raw error sources
//   error_status_o[15:0]       : sticky status ([8] = FIFO overflow)
//   error_clear_i              : clears status[8:0]
//   error_interrupt_i          : counted into irq_count (saturating)
//   irq_o                      : registered (status != 0)
module sdcard_error_status_unit
  import sdcard_error_pkg::*;
(
  input  logic        PCLK_i,
  input  logic        PRESETn_i,
  input  logic        PSEL_i,
  input  logic        PENABLE_i,
  input  logic        PWRITE_i,
  input  logic [3:0]  PADDR_i,
  input  logic [31:0] PWDATA_i,
  output logic [31:0] PRDATA_o,
  output logic        PREADY_o,
  output logic        PSLVERR_o,
  input  logic [7:0]  err_src_i,
  output logic [15:0] error_status_o,
  input  logic        error_clear_i,
  input  logic        error_interrupt_i,
  output logic        irq_o
);

  logic [7:0]         src_prev_reg;
  logic [7:0]         mask_reg;
  logic [8:0]         status_reg;
  logic [8:0]         status_next;
  logic [8:0]         status_set;
  logic [8:0]         status_clr;
  logic [15:0]        timestamp_reg;
  logic [15:0]        irq_count_reg;
  logic               irq_reg;
  logic               access;
  logic               aligned;
  logic               wr_en;
  logic               rd_en;
  logic [7:0]         events;
  logic [7:0]         unmasked;
  err_entry_t         push_entry;
  err_entry_t         head_entry;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_drop;
  logic               fifo_empty;
  logic               fifo_full;
  logic [LEVEL_W-1:0] fifo_level;
  logic               unused;

  // Gating with reset keeps the APB outputs quiet while reset is held.
  assign access  = PSEL_i & PENABLE_i & PRESETn_i;
  assign aligned = (PADDR_i[1:0] == 2'b00);
  assign wr_en   = access & aligned & PWRITE_i;
  assign rd_en   = access & aligned & ~PWRITE_i;

  assign events     = err_src_i & ~src_prev_reg;
  assign unmasked   = events & ~mask_reg;
  assign fifo_push  = |unmasked;
  assign push_entry = '{code: lowest_code(unmasked), timestamp: timestamp_reg};
  assign fifo_pop   = rd_en & (PADDR_i == REG_FIFO_DATA);

  sdcard_error_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .PCLK_i    (PCLK_i),
    .PRESETn_i (PRESETn_i),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .drop      (fifo_drop)
  );

  assign status_set = {fifo_drop, unmasked};
  assign status_clr = {9{error_clear_i}} |
                      ((wr_en && PADDR_i == REG_STATUS) ? PWDATA_i[8:0] : 9'd0);

  // Per bit, a set in the same cycle beats any clear.
  for (genvar gi = 0; gi < 9; gi++) begin : g_status
    assign status_next[gi] = status_set[gi] | (status_reg[gi] & ~status_clr[gi]);
  end

  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      src_prev_reg  <= '0;
      mask_reg      <= '0;
      status_reg    <= '0;
      timestamp_reg <= '0;
      irq_count_reg <= '0;
      irq_reg       <= 1'b0;
    end else begin
      src_prev_reg  <= err_src_i;
      status_reg    <= status_next;
      timestamp_reg <= timestamp_reg + 16'd1;
      irq_reg       <= |status_reg;
      if (wr_en && PADDR_i == REG_MASK) mask_reg <= PWDATA_i[7:0];
      if (error_interrupt_i && irq_count_reg != 16'hFFFF)
        irq_count_reg <= irq_count_reg + 16'd1;
    end
  end

  always_comb begin
    PRDATA_o = 32'd0;
    if (rd_en) begin
      case (PADDR_i)
        REG_STATUS:    PRDATA_o = {23'd0, status_reg};
        REG_MASK:      PRDATA_o = {24'd0, mask_reg};
        REG_FIFO_DATA: PRDATA_o = fifo_empty ? 32'd0 : {1'b1, 11'd0, head_entry};
        REG_COUNT:     PRDATA_o = {irq_count_reg, 12'd0, fifo_level};
        default:       PRDATA_o = 32'd0;
      endcase
    end
  end

  assign PSLVERR_o      = access & ~aligned;
  assign PREADY_o       = 1'b1;
  assign error_status_o = {7'd0, status_reg};
  assign irq_o          = irq_reg;

  assign unused = &{1'b0, PWDATA_i[31:9], fifo_full};

endmodule
